// File: rtl/bus_xbar_if.sv
// Bus bundle between the two masters/arbiter, the crossbar and the two memory
// slaves.
//
// Signals:
//   m0_grant, m1_grant          one-hot grant pair from the arbiter
//   m0_wr/m0_addr/m0_dout       master 0 request
//   m1_wr/m1_addr/m1_dout       master 1 request
//   s0_dout, s1_dout            slave read data (1-cycle registered latency)
//   s0_sel, s1_sel              slave selects
//   s_addr, s_wr, s_din         routed request towards the slaves
//   m_din                       read data returned to both masters
//   bus_err                     one-cycle pulse after an unmapped access
//
// Modports:
//   slave  - the crossbar itself; it consumes the master side of the bus
//   master - the surrounding environment: masters, arbiter and memory slaves
interface bus_xbar_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              m0_grant;
    logic              m1_grant;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_dout;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_dout;
    logic [DATA_W-1:0] s0_dout;
    logic [DATA_W-1:0] s1_dout;
    logic              s0_sel;
    logic              s1_sel;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] m_din;
    logic              bus_err;

    modport slave (
        input  m0_grant, m1_grant,
        input  m0_wr, m0_addr, m0_dout,
        input  m1_wr, m1_addr, m1_dout,
        input  s0_dout, s1_dout,
        output s0_sel, s1_sel, s_addr, s_wr, s_din,
        output m_din, bus_err
    );

    modport master (
        output m0_grant, m1_grant,
        output m0_wr, m0_addr, m0_dout,
        output m1_wr, m1_addr, m1_dout,
        output s0_dout, s1_dout,
        input  s0_sel, s1_sel, s_addr, s_wr, s_din,
        input  m_din, bus_err
    );
endinterface

// File: rtl/bus_xbar.sv
// Two-master / two-slave shared-bus crossbar.
// Routes the granted master's request to the slave picked by address decode,
// returns slave read data one cycle later and flags unmapped accesses.
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      bus_xbar_if.slave bundle (grants, master requests, slave read
//            data in; slave selects, routed request, m_din, bus_err out)
module bus_xbar #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int SLV_AW    = 5,
    parameter int S0_REGION = 0,
    parameter int S1_REGION = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    bus_xbar_if.slave  bus
);
    localparam int REG_W = ADDR_W - SLV_AW;
    localparam logic [REG_W-1:0] S0_IDX = REG_W'(S0_REGION);
    localparam logic [REG_W-1:0] S1_IDX = REG_W'(S1_REGION);

    logic              active;
    logic [ADDR_W-1:0] s_addr;
    logic              s_wr;
    logic [DATA_W-1:0] s_din;
    logic [REG_W-1:0]  region;
    logic              s0_hit;
    logic              s1_hit;
    logic              unmapped;
    logic [1:0]        rd_sel_p1;
    logic              bus_err_p1;

    // ---- stage 0: master mux and address decode (combinational) ----
    always_comb begin
        active = 1'b0;
        s_addr = '0;
        s_wr   = 1'b0;
        s_din  = '0;
        unique case ({bus.m0_grant, bus.m1_grant})
            2'b10: begin
                active = 1'b1;
                s_addr = bus.m0_addr;
                s_wr   = bus.m0_wr;
                s_din  = bus.m0_dout;
            end
            2'b01: begin
                active = 1'b1;
                s_addr = bus.m1_addr;
                s_wr   = bus.m1_wr;
                s_din  = bus.m1_dout;
            end
            default: begin
                // no grant or an illegal double grant: keep the bus quiet
            end
        endcase
    end

    assign region   = s_addr[ADDR_W-1:SLV_AW];
    assign s0_hit   = active && (region == S0_IDX);
    // slave 0 wins if both regions were configured identically, so the
    // selects stay mutually exclusive
    assign s1_hit   = active && (region == S1_IDX) && !s0_hit;
    assign unmapped = active && !s0_hit && !s1_hit;

    assign bus.s0_sel = s0_hit;
    assign bus.s1_sel = s1_hit;
    assign bus.s_addr = s_addr;
    assign bus.s_wr   = s_wr;
    assign bus.s_din  = s_din;

    // ---- stage 1: remember which slave owes read data, register error ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sel_p1  <= 2'b00;
            bus_err_p1 <= 1'b0;
        end else begin
            rd_sel_p1  <= {s0_hit & ~s_wr, s1_hit & ~s_wr};
            bus_err_p1 <= unmapped;
        end
    end

    // ---- stage 1 output: read-return mux, independent of the current grant ----
    always_comb begin
        unique case (rd_sel_p1)
            2'b10:   bus.m_din = bus.s0_dout;
            2'b01:   bus.m_din = bus.s1_dout;
            default: bus.m_din = '0;
        endcase
    end

    assign bus.bus_err = bus_err_p1;
endmodule
